cia: RTL and testbench

- 32-bit carry increment adder (CIA) computing {cout, sum} = a + b + cin.
- Operand slices are added in parallel, with carry-in assumed 0 in each slice. A per-slice incrementer then folds the incoming carry in, so the carry chain ripples across slices and not across bits.
- Sits under the adder controller, which loads 32-bit operands a byte at a time and displays the sum one byte at a time.
- Result is registered: one clock of latency.

---
 rtl/cia_pkg.sv | 7 +
 rtl/cia_block.sv | 44 ++++
 rtl/cia.sv | 46 ++++
 tb/tb_cia.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cia_pkg.sv
// Shared constants for the carry increment adder.
package cia_pkg;

  localparam int CIA_WIDTH = 32;
  localparam int CIA_BLOCK = 4;

endpackage

// File: rtl/cia_block.sv
// One carry-increment slice.
// A zero-carry ripple adder forms the partial sum s0 and the slice generate g.
// An incrementer then folds in the incoming slice carry.
// The slice carry-out is g | (c_in & s0 all ones). It never waits on a ripple through the adder bits.
module cia_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_s,
  input  logic [BLOCK-1:0] b_s,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out
);

  logic [BLOCK-1:0] s0;
  logic             g;

  // Ripple adder with carry-in tied low; its final carry is the slice generate
  always_comb begin
    logic rc;
    s0 = '0;
    rc = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i] = a_s[i] ^ b_s[i] ^ rc;
      rc    = (a_s[i] & b_s[i]) | (rc & (a_s[i] ^ b_s[i]));
    end
    g = rc;
  end

  // Incrementer adds the incoming carry to the partial sum (half-adder chain)
  always_comb begin
    logic ic;
    s  = '0;
    ic = c_in;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = s0[i] ^ ic;
      ic   = ic & s0[i];
    end
  end

  // g and an all-ones partial sum cannot both be true, so OR-ing them is exact
  assign c_out = g | (c_in & (&s0));

endmodule

// File: rtl/cia.sv
// 32-bit carry increment adder with a registered result.
// Slices add in parallel, and the carry ripples slice-to-slice through the incrementers.
module cia
  import cia_pkg::*;
#(
  parameter int WIDTH = CIA_WIDTH,
  parameter int BLOCK = CIA_BLOCK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / BLOCK;

  logic [NSLICE:0]  carry;
  logic [WIDTH-1:0] sum_next;

  assign carry[0] = cin;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    cia_block #(.BLOCK(BLOCK)) u_block (
      .a_s   (a[k*BLOCK +: BLOCK]),
      .b_s   (b[k*BLOCK +: BLOCK]),
      .c_in  (carry[k]),
      .s     (sum_next[k*BLOCK +: BLOCK]),
      .c_out (carry[k+1])
    );
  end

  // Output register; reset wins over capturing the freshly computed sum
  always_ff @(posedge clk) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= carry[NSLICE];
    end
  end

endmodule

// File: tb/tb_cia.sv
// Self-checking bench for the carry increment adder.
// Expected results come from plain 33-bit arithmetic with a one-cycle delay.
module tb_cia;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;

  logic [31:0] exp_sum;
  logic        exp_cout;
  int          total;
  int          bad;

  cia dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of inputs at the falling edge and compute the expected result.
  // Then advance to just after the next rising edge, where the result must appear.
  task automatic applyStimulus(input logic [31:0] a_v, input logic [31:0] b_v,
                               input logic c_v, input logic r_v);
    logic [32:0] full;
    @(negedge clk);
    a     = a_v;
    b     = b_v;
    cin   = c_v;
    reset = r_v;
    full  = {1'b0, a_v} + {1'b0, b_v} + {32'd0, c_v};
    if (r_v) begin
      exp_sum  = 32'd0;
      exp_cout = 1'b0;
    end else begin
      exp_sum  = full[31:0];
      exp_cout = full[32];
    end
    @(posedge clk);
    #1;
  endtask

  // Compare both outputs against the model's expectation
  task automatic checkOutput(input string tag);
    total++;
    assert (sum === exp_sum) else begin
      bad++;
      $error("[TB] FAIL %s sum observed=%h expected=%h", tag, sum, exp_sum);
    end
    total++;
    assert (cout === exp_cout) else begin
      bad++;
      $error("[TB] FAIL %s cout observed=%b expected=%b", tag, cout, exp_cout);
    end
  endtask

  // Directed steps followed by a long randomized run with occasional resets
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rr;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    applyStimulus(32'h12345678, 32'h11111111, 1'b1, 1'b1);
    checkOutput("reset");
    applyStimulus(32'h12345678, 32'h11111111, 1'b1, 1'b0);
    checkOutput("post_reset");

    // The result must hold between edges
    @(negedge clk);
    checkOutput("hold");

    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    checkOutput("byte_carry");
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    checkOutput("full_propagate");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    checkOutput("max_cin1");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("max_cin0");
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    checkOutput("b2b_msb");
    applyStimulus(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0);
    checkOutput("b2b_alt");
    applyStimulus(32'h00000000, 32'h00000000, 1'b0, 1'b0);
    checkOutput("zero");
    applyStimulus(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1);
    checkOutput("mid_reset");
    applyStimulus(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
    checkOutput("resume");

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFFFFFF;
        1: rb = ~ra;
        default: ;
      endcase
      applyStimulus(ra, rb, rc, rr);
      checkOutput("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
